// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the supervisor FSM state encoding and the timer-width calculation.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } pll_state_e;

  // One timer serves every state, so it must hold the largest cycle count.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Reusable for any slow-changing level crossing into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Watches rPLL lock on the free-running board clock, drives PLL reset and the
// video-pipeline reset, and counts timeouts and lock losses (saturating).
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock_in,
  input  logic             clr_stats,
  output logic             pll_reset,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [2:0]       state_dbg
);

  localparam int unsigned TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                           LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] T_RST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_TO  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ST  = TW'(LOCK_STABLE_CYCLES - 1);

  logic          lock_s;
  pll_state_e    state, nxt;
  logic [TW-1:0] timer;
  logic          inc_timeout, inc_loss;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock_in),
    .q   (lock_s)
  );

  always_comb begin
    nxt         = state;
    inc_timeout = 1'b0;
    inc_loss    = 1'b0;
    case (state)
      PLL_RST:   if (timer == T_RST) nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still wins.
        if (lock_s) nxt = STABILIZE;
        else if (timer == T_TO) begin
          nxt         = PLL_RST;
          inc_timeout = 1'b1;
        end
      end
      STABILIZE: begin
        if (!lock_s)            nxt = WAIT_LOCK;
        else if (timer == T_ST) nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          nxt      = LOST;
          inc_loss = 1'b1;
        end
      end
      LOST:      nxt = PLL_RST;
      default:   nxt = PLL_RST;
    endcase
  end

  // Outputs are decoded from nxt so they move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= PLL_RST;
      timer         <= '0;
      loss_count    <= '0;
      timeout_count <= '0;
      pll_reset     <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)   timer <= '0;
      else if (state != RUN) timer <= timer + 1'b1;

      if (clr_stats)                             timeout_count <= '0;
      else if (inc_timeout && timeout_count != '1) timeout_count <= timeout_count + 1'b1;

      if (clr_stats)                       loss_count <= '0;
      else if (inc_loss && loss_count != '1) loss_count <= loss_count + 1'b1;

      pll_reset <= (nxt == PLL_RST);
      ready     <= (nxt == RUN);
      sys_rst   <= (nxt != RUN);
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer-side companion to the Gowin rPLL wrapper. It watches the PLL `lock` output, drives the PLL `RESET` input, and generates the video-pipeline reset (pixel/TMDS logic).
- Runs on the free-running 27 MHz board clock, never on a PLL output. It re-synchronises `lock` to that clock and debounces it. It forces PLL re-acquisition on lock timeout or lock loss, and keeps saturating statistics.

Parameters:
- PLL_RST_CYCLES, 16: width of the `pll_reset` pulse in clk cycles (must be ≥2).
- LOCK_TIMEOUT_CYCLES, 65536: maximum cycles in WAIT_LOCK before the PLL is reset again (must be ≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before release (must be ≥2).
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  free-running 27 MHz reference clock
- rst  in  1  asynchronous, active-high reset
- pll_lock_in  in  1  rPLL LOCK; asynchronous to clk
- clr_stats  in  1  synchronous clear of both statistics counters
- pll_reset  out  1  to rPLL RESET; active-high
- sys_rst  out  1  active-high reset to downstream video logic
- ready  out  1  high only in RUN
- loss_count  out  CNT_W  lock losses seen while in RUN; saturating
- timeout_count  out  CNT_W  WAIT_LOCK timeouts; saturating
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (rst=1, async):
  - state=PLL_RST, all timers=0, both synchroniser flops=0, both statistics counters=0.
  - pll_reset=1, sys_rst=1, ready=0.
- Synchroniser: pll_lock_in passes through 2 flops to give lock_s. This adds 2 cycles of latency; there is no other filtering.
- Outputs are registered and decoded from next-state, so they change on the same edge as the state transition.
  - pll_reset=1 only in PLL_RST.
  - ready=1 only in RUN.
  - sys_rst=1 in every state except RUN.
- Single timer, width clog2 of the largest of the three cycle parameters. It clears on every state change.
- PLL_RST: timer counts up. At timer==PLL_RST_CYCLES-1, go to WAIT_LOCK. lock_s is ignored.
- WAIT_LOCK:
  - lock_s=1: go to STABILIZE.
  - Otherwise, at timer==LOCK_TIMEOUT_CYCLES-1: go to PLL_RST and increment timeout_count.
  - If both conditions hold in the same cycle, lock_s=1 wins.
- STABILIZE:
  - lock_s=0: go to WAIT_LOCK with the timer restarted. This is not a timeout and is not counted.
  - lock_s=1 and timer==LOCK_STABLE_CYCLES-1: go to RUN.
- RUN: lock_s=0: go to LOST and increment loss_count.
- LOST: lasts 1 cycle, then go to PLL_RST unconditionally.
- Latency from pll_lock_in falling in RUN to sys_rst=1/ready=0 is at most 3 clk edges.
- Ideal bring-up from rst release to ready=1:
  - PLL_RST_CYCLES, plus WAIT_LOCK dwell, plus LOCK_STABLE_CYCLES.
  - Plus 2 synchroniser cycles measured from lock assertion.
- Statistics counters:
  - Saturate at all-ones with no wrap.
  - clr_stats=1 zeroes both on the next edge. Clear wins over a simultaneous increment.
- Glitch on pll_lock_in shorter than 1 clk: may or may not be captured. If captured in RUN, it is treated as a real loss.
- Encodings: PLL_RST=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, LOST=4. Values 5–7 are illegal and recover to PLL_RST on the next edge.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum (3-bit) with the encodings above;
  - the function computing timer width from the parameters.
- One sub-module, sync_2ff (1-bit, async reset to 0). It is reusable for other CDC crossings.
- FSM, timer and counters stay in the top module.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, CNT_W=2.
1. Nominal bring-up: release rst, raise pll_lock_in 10 cycles later and hold. Required: pll_reset high for exactly 4 cycles; ready=1/sys_rst=0 exactly 2+8 cycles after lock_s entry timing; both counters stay 0.
2. No lock: hold pll_lock_in=0. Required: pll_reset pulses (4 wide) repeat every 4+32 cycles; timeout_count goes 1,2,3 and then stays 3; ready stays 0.
3. Lock bounce: in STABILIZE, drop lock for 2 cycles at stable count 5, then hold high. Required: state returns to WAIT_LOCK; RUN is reached only after a fresh 8 consecutive cycles; no counter increments.
4. Lock loss in RUN: deassert pll_lock_in. Required: within 3 edges sys_rst=1, ready=0, state passes LOST for 1 cycle, then pll_reset=1; loss_count=1.
5. Clear vs increment: assert clr_stats in the same cycle as a RUN→LOST transition with loss_count=2. Required: loss_count=0 on the next edge.
6. Async reset mid-operation: assert rst during STABILIZE between clock edges. Required: pll_reset=1, sys_rst=1, ready=0, counters=0 immediately with no clk edge; bring-up restarts after release.
